// File: rtl/rebote_multi.sv
// rebote_multi: per-channel synchronise + debounce with press/release pulses; long-press pulse under REBOTE_LARGO_EN
module rebote_multi #(
    parameter int N_CH         = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int DEB_CYCLES   = 50000,
    parameter int CNT_W        = 16,
    parameter int LARGO_CYCLES = 1000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] boton,
    output logic [N_CH-1:0] boton_sal,
    output logic [N_CH-1:0] pulso_sub,
    output logic [N_CH-1:0] pulso_baj,
    output logic [N_CH-1:0] pulso_largo
);
    localparam logic [CNT_W-1:0] C_FIN = CNT_W'(DEB_CYCLES - 1);
    if (N_CH < 1 || SYNC_STAGES < 2 || DEB_CYCLES < 1 || LARGO_CYCLES < 1 ||
        ((DEB_CYCLES - 1) >> CNT_W) != 0) begin : g_param_err
        $error("rebote_multi: illegal parameter set");
    end
`ifdef REBOTE_LARGO_EN
    localparam int LW = $clog2(LARGO_CYCLES + 1);
    localparam logic [LW-1:0] L_FIN = LW'(LARGO_CYCLES - 1);
`endif
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        logic [CNT_W-1:0]       cnt_q, cnt_d;
        logic                   sal_q, sal_d, sub_q, sub_d, baj_q, baj_d;
        logic                   sy, diff, fin;
        always_comb begin
            sync_d = {sync_q[SYNC_STAGES-2:0], boton[i]};
            sy     = sync_q[SYNC_STAGES-1];
            diff   = sy != sal_q;
            fin    = diff && cnt_q == C_FIN;
            cnt_d  = (diff && !fin) ? cnt_q + 1'b1 : '0;
            sal_d  = fin ? sy : sal_q;
            sub_d  = fin && sy;
            baj_d  = fin && !sy;
        end
        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q <= '0;
                cnt_q  <= '0;
                sal_q  <= 1'b0;
                sub_q  <= 1'b0;
                baj_q  <= 1'b0;
            end else begin
                sync_q <= sync_d;
                cnt_q  <= cnt_d;
                sal_q  <= sal_d;
                sub_q  <= sub_d;
                baj_q  <= baj_d;
            end
        end
        assign boton_sal[i] = sal_q;
        assign pulso_sub[i] = sub_q;
        assign pulso_baj[i] = baj_q;
`ifdef REBOTE_LARGO_EN
        logic [LW-1:0] lc_q, lc_d;
        logic          flag_q, flag_d, largo_q, largo_d;
        // counter saturates at L_FIN; the flag blocks a repeat pulse until release
        always_comb begin
            lc_d    = !sal_q ? '0 : (lc_q == L_FIN ? lc_q : lc_q + 1'b1);
            largo_d = sal_q && !flag_q && lc_d == L_FIN;
            flag_d  = sal_q && (flag_q || largo_d);
        end
        always_ff @(posedge clk) begin
            if (rst) begin
                lc_q    <= '0;
                flag_q  <= 1'b0;
                largo_q <= 1'b0;
            end else begin
                lc_q    <= lc_d;
                flag_q  <= flag_d;
                largo_q <= largo_d;
            end
        end
        assign pulso_largo[i] = largo_q;
`else
        assign pulso_largo[i] = 1'b0;
`endif
    end
endmodule

// File: tb/tb_rebote_multi.sv
// tb_rebote_multi: directed + random stimulus, window-based reference model, queue scoreboard
module tb_rebote_multi;
    localparam int NC = 2, SS = 2, DEB = 4, LARGO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NC-1:0] boton = '0;
    logic [NC-1:0] boton_sal, pulso_sub, pulso_baj, pulso_largo;

    rebote_multi #(
        .N_CH(NC), .SYNC_STAGES(SS), .DEB_CYCLES(DEB), .CNT_W(16), .LARGO_CYCLES(LARGO)
    ) dut (
        .clk(clk), .rst(rst), .boton(boton), .boton_sal(boton_sal),
        .pulso_sub(pulso_sub), .pulso_baj(pulso_baj), .pulso_largo(pulso_largo)
    );

    always #10 clk = ~clk;

    // model state: raw-input delay line, window of recent synchronised samples, level, time held high
    bit         pipe [NC][SS];
    bit         win  [NC][$];
    bit         s_m  [NC];
    int         age  [NC];
    logic [7:0] exp_q [$];
    int         compared = 0, mismatched = 0, cyc = 0;

    task automatic model(input logic r, input logic [NC-1:0] b);
        logic [NC-1:0] es, esub, ebaj, elg;
        bit            sy, all_diff;
        for (int c = 0; c < NC; c++) begin
            esub[c] = 1'b0;
            ebaj[c] = 1'b0;
            elg[c]  = 1'b0;
            if (r) begin
                for (int k = 0; k < SS; k++) pipe[c][k] = 1'b0;
                win[c].delete();
                s_m[c] = 1'b0;
                age[c] = 0;
            end else begin
                sy = pipe[c][SS-1];
                win[c].push_back(sy);
                if (win[c].size() > DEB) void'(win[c].pop_front());
                all_diff = win[c].size() == DEB;
                foreach (win[c][k]) if (win[c][k] == s_m[c]) all_diff = 1'b0;
`ifdef REBOTE_LARGO_EN
                if (s_m[c]) begin
                    age[c]++;
                    elg[c] = age[c] == LARGO - 1;
                end else age[c] = 0;
`endif
                if (all_diff) begin
                    s_m[c]  = sy;
                    esub[c] = sy;
                    ebaj[c] = !sy;
                end
                for (int k = SS - 1; k > 0; k--) pipe[c][k] = pipe[c][k-1];
                pipe[c][0] = b[c];
            end
            es[c] = s_m[c];
        end
        exp_q.push_back({es, esub, ebaj, elg});
    endtask

    task automatic step(input logic r, input logic [NC-1:0] b);
        rst   = r;
        boton = b;
        @(posedge clk);
        #1;
        model(r, b);
    endtask

    task automatic hold(input logic r, input logic [NC-1:0] b, input int n);
        for (int k = 0; k < n; k++) step(r, b);
    endtask

    always @(negedge clk) begin
        logic [7:0] e, got;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {boton_sal, pulso_sub, pulso_baj, pulso_largo};
            compared++;
            if (got !== e) begin
                mismatched++;
                $display("FAIL cyc%0d sal/sub/baj/largo: got %b_%b_%b_%b want %b_%b_%b_%b",
                         cyc, got[7:6], got[5:4], got[3:2], got[1:0], e[7:6], e[5:4], e[3:2], e[1:0]);
            end
            cyc++;
        end
    end

    initial begin
        logic [NC-1:0] rb;
        hold(1'b1, 2'b11, 3);
        hold(1'b0, 2'b11, 8);
        hold(1'b0, 2'b00, 8);
        hold(1'b0, 2'b01, 3);
        hold(1'b0, 2'b00, 8);
        step(1'b0, 2'b01); step(1'b0, 2'b00); step(1'b0, 2'b01); step(1'b0, 2'b00);
        hold(1'b0, 2'b01, 10);
        step(1'b0, 2'b00); step(1'b0, 2'b01); step(1'b0, 2'b00); step(1'b0, 2'b01);
        hold(1'b0, 2'b00, 10);
        hold(1'b0, 2'b11, 8);
        hold(1'b0, 2'b01, 8);
        hold(1'b0, 2'b00, 8);
        hold(1'b0, 2'b01, 4);
        step(1'b1, 2'b01);
        hold(1'b0, 2'b01, 8);
        hold(1'b0, 2'b00, 8);
        hold(1'b0, 2'b01, 20);
        hold(1'b0, 2'b00, 8);
        rb = '0;
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < NC; c++) if ($urandom_range(0, 5) == 0) rb[c] = ~rb[c];
            step($urandom_range(0, 99) == 0, rb);
        end
        hold(1'b0, rb, 2);
        @(negedge clk);
        #1;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
